md_ex_sequencer: RTL and testbench

- Parametrised execute-stage controller for the RV32M/RV64M multiply/divide extension; sits beside the ALU in EX.
- Decodes ALUOp/Funct7/Funct3 for M-extension R-type ops and runs them as a multi-cycle iterative unit.
- Stalls the pipeline while busy and returns a result with a one-cycle done pulse.
- Non-M ops pass through untouched; the existing ALU keeps handling them.

---
 rtl/md_ex_sequencer_if.sv | 26 ++
 rtl/md_ex_sequencer.sv | 170 +++++++++++++++++
 tb/tb_md_ex_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_ex_sequencer_if.sv
// rtl/md_ex_sequencer_if.sv - EX-stage bus between pipeline and multiply/divide sequencer
interface md_ex_sequencer_if #(
   parameter int XLEN = 32
);
   logic [1:0]      ALUOp;
   logic [6:0]      Funct7;
   logic [2:0]      Funct3;
   logic            ex_valid;
   logic            flush;
   logic [XLEN-1:0] SrcA;
   logic [XLEN-1:0] SrcB;
   logic            md_sel;
   logic            md_stall;
   logic            md_done;
   logic [XLEN-1:0] md_result;

   modport master (
      output ALUOp, Funct7, Funct3, ex_valid, flush, SrcA, SrcB,
      input  md_sel, md_stall, md_done, md_result
   );

   modport slave (
      input  ALUOp, Funct7, Funct3, ex_valid, flush, SrcA, SrcB,
      output md_sel, md_stall, md_done, md_result
   );
endinterface

// File: rtl/md_ex_sequencer.sv
// rtl/md_ex_sequencer.sv - iterative M-extension multiply/divide sequencer for EX (option macro: MD_FAST_MUL_EN)
module md_ex_sequencer #(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             reset,
   md_ex_sequencer_if.slave md
);
   localparam int               CNT_W    = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   op_a;
   logic [XLEN-1:0]   op_b;
   logic [2*XLEN-1:0] acc;
   logic [2:0]        f3_q;
   logic              neg_q;
   logic              neg_r;
   logic              md_done_q;
   logic [XLEN-1:0]   md_result_q;

   logic              accept;
   logic              signed_a;
   logic              signed_b;
   logic              sgn_a;
   logic              sgn_b;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     rem_diff;
   logic [2*XLEN-1:0] acc_mul;
   logic [2*XLEN-1:0] acc_div;
   logic [2*XLEN-1:0] mul_full;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   mul_res;
   logic [XLEN-1:0]   div_res;

   assign md.md_sel    = (md.ALUOp == 2'b10) && (md.Funct7 == 7'b0000001);
   assign accept       = (state == S_IDLE) && md.ex_valid && md.md_sel && !md.flush;
   assign md.md_stall  = accept || (state == S_MUL) || (state == S_DIV);
   assign md.md_done   = md_done_q;
   assign md.md_result = md_result_q;

   // Operand decode: which operands are signed, their magnitudes, and the divide special cases.
   always_comb begin
      signed_a = (md.Funct3 != 3'b011) && (md.Funct3 != 3'b101) && (md.Funct3 != 3'b111);
      signed_b = signed_a && (md.Funct3 != 3'b010);
      sgn_a    = signed_a && md.SrcA[XLEN-1];
      sgn_b    = signed_b && md.SrcB[XLEN-1];
      abs_a    = sgn_a ? -md.SrcA : md.SrcA;
      abs_b    = sgn_b ? -md.SrcB : md.SrcB;
      div_zero = md.Funct3[2] && (md.SrcB == '0);
      div_ovf  = md.Funct3[2] && !md.Funct3[0] && (md.SrcA == MOST_NEG) && (md.SrcB == '1);
   end

   // One iteration of shift-add multiply and restoring divide, plus the sign-fixed final results.
   always_comb begin
      mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_a} : {(XLEN+1){1'b0}});
      acc_mul  = {mul_sum, acc[XLEN-1:1]};
      rem_sh   = acc[2*XLEN-1:XLEN-1];
      rem_diff = rem_sh - {1'b0, op_b};
      if (!rem_diff[XLEN]) begin
         acc_div = {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
         acc_div = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
      mul_full = neg_q ? -acc_mul : acc_mul;
      mul_res  = (f3_q == 3'b000) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
      quo      = acc_div[XLEN-1:0];
      rem      = acc_div[2*XLEN-1:XLEN];
      div_res  = f3_q[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
   end

`ifdef MD_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   logic [2*XLEN-1:0] fast_full;

   // Single-cycle magnitude product, sign applied afterwards like the iterative path.
   always_comb begin
      fast_prod = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
      fast_full = (sgn_a ^ sgn_b) ? -fast_prod : fast_prod;
   end
`endif

   // Sequencer FSM: accept, iterate XLEN steps (or shortcut to DONE), pulse done, honour flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         op_a        <= '0;
         op_b        <= '0;
         acc         <= '0;
         f3_q        <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         md_done_q   <= 1'b0;
         md_result_q <= '0;
      end else begin
         md_done_q <= 1'b0;
         if (md.flush) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept) begin
                     f3_q  <= md.Funct3;
                     op_a  <= abs_a;
                     op_b  <= abs_b;
                     neg_q <= sgn_a ^ sgn_b;
                     neg_r <= sgn_a;
                     cnt   <= '0;
                     if (div_zero) begin
                        state       <= S_DONE;
                        md_done_q   <= 1'b1;
                        md_result_q <= md.Funct3[1] ? md.SrcA : '1;
                     end else if (div_ovf) begin
                        state       <= S_DONE;
                        md_done_q   <= 1'b1;
                        md_result_q <= md.Funct3[1] ? '0 : md.SrcA;
`ifdef MD_FAST_MUL_EN
                     end else if (!md.Funct3[2]) begin
                        state       <= S_DONE;
                        md_done_q   <= 1'b1;
                        md_result_q <= (md.Funct3 == 3'b000) ? fast_full[XLEN-1:0]
                                                             : fast_full[2*XLEN-1:XLEN];
`endif
                     end else if (md.Funct3[2]) begin
                        state <= S_DIV;
                        acc   <= {{XLEN{1'b0}}, abs_a};
                     end else begin
                        state <= S_MUL;
                        acc   <= {{XLEN{1'b0}}, abs_b};
                     end
                  end
               end
               S_MUL: begin
                  acc <= acc_mul;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state       <= S_DONE;
                     md_done_q   <= 1'b1;
                     md_result_q <= mul_res;
                  end
               end
               S_DIV: begin
                  acc <= acc_div;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state       <= S_DONE;
                     md_done_q   <= 1'b1;
                     md_result_q <= div_res;
                  end
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_md_ex_sequencer.sv
// tb/tb_md_ex_sequencer.sv - self-checking bench for md_ex_sequencer
module tb_md_ex_sequencer;
   localparam int XLEN = 32;
`ifdef MD_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = XLEN + 1;
`endif
   localparam int DIV_LAT = XLEN + 1;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   md_ex_sequencer_if #(.XLEN(XLEN)) bus ();

   md_ex_sequencer #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bus.ALUOp    = 2'b10;
      bus.Funct7   = 7'b0000001;
      bus.Funct3   = f3;
      bus.SrcA     = a;
      bus.SrcB     = b;
      bus.ex_valid = 1'b1;
   endtask

   // Present an M op in the current cycle, expect it to be accepted, wait (bounded) for done.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int stalls);
      drive_m(f3, a, b);
      #1;
      chk("accept_sel", 32'(bus.md_sel), 32'd1);
      chk("accept_stall", 32'(bus.md_stall), 32'd1);
      stalls = bus.md_stall ? 1 : 0;
      tick();
      bus.ex_valid = 1'b0;
      lat = 1;
      while (!bus.md_done && lat < 100) begin
         if (bus.md_stall) stalls++;
         tick();
         lat++;
      end
      chk("done_cycle_stall", 32'(bus.md_stall), 32'd0);
      res = bus.md_result;
   endtask

   // Reference result straight from the RISC-V M-extension definitions, using wide integer math.
   function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      int          ia, ib;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      ia = $signed(a);
      ib = $signed(b);
      p  = '0;
      r  = '0;
      case (f3)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib);
         3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(ia % ib);
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return MUL_LAT;
      if (b == 0) return 1;
      if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return DIV_LAT;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      vec_t        vecs [16];
      logic [31:0] res;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rf3;
      int          lat;
      int          stalls;
      int          spurious;

      vecs[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT};
      vecs[1]  = '{3'b001, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, MUL_LAT};
      vecs[2]  = '{3'b011, 32'd7,          32'hFFFFFFFD, 32'h00000006, MUL_LAT};
      vecs[3]  = '{3'b010, 32'hFFFFFFFD,   32'd7,        32'hFFFFFFFF, MUL_LAT};
      vecs[4]  = '{3'b100, 32'hFFFFFFEC,   32'd3,        32'hFFFFFFFA, DIV_LAT};
      vecs[5]  = '{3'b110, 32'hFFFFFFEC,   32'd3,        32'hFFFFFFFE, DIV_LAT};
      vecs[6]  = '{3'b101, 32'd100,        32'd7,        32'd14,       DIV_LAT};
      vecs[7]  = '{3'b111, 32'd100,        32'd7,        32'd2,        DIV_LAT};
      vecs[8]  = '{3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
      vecs[9]  = '{3'b110, 32'd5,          32'd0,        32'd5,        1};
      vecs[10] = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
      vecs[11] = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
      vecs[12] = '{3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 1};
      vecs[13] = '{3'b111, 32'd5,          32'd0,        32'd5,        1};
      vecs[14] = '{3'b101, 32'h80000000,   32'hFFFFFFFF, 32'd0,        DIV_LAT};
      vecs[15] = '{3'b111, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, DIV_LAT};

      reset        = 1'b0;
      bus.ALUOp    = 2'b00;
      bus.Funct7   = 7'd0;
      bus.Funct3   = 3'd0;
      bus.SrcA     = '0;
      bus.SrcB     = '0;
      bus.ex_valid = 1'b0;
      bus.flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_stall", 32'(bus.md_stall), 32'd0);
      chk("reset_done", 32'(bus.md_done), 32'd0);
      chk("reset_result", bus.md_result, 32'd0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, stalls);
         chk($sformatf("vec%0d_result", i), res, vecs[i].res);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("vec%0d_stall_cycles", i), 32'(stalls), 32'(vecs[i].lat));
         tick();
      end

      // Non-M instructions: no select, no stall.
      bus.ALUOp    = 2'b10;
      bus.Funct7   = 7'd0;
      bus.Funct3   = 3'd0;
      bus.ex_valid = 1'b1;
      #1;
      chk("add_sel", 32'(bus.md_sel), 32'd0);
      chk("add_stall", 32'(bus.md_stall), 32'd0);
      tick();
      chk("add_stall_next", 32'(bus.md_stall), 32'd0);
      chk("add_done_next", 32'(bus.md_done), 32'd0);
      bus.ALUOp  = 2'b00;
      bus.Funct7 = 7'b0000001;
      #1;
      chk("aluop00_sel", 32'(bus.md_sel), 32'd0);
      bus.ex_valid = 1'b0;
      tick();

      // Flush in the accept cycle blocks acceptance.
      drive_m(3'b101, 32'd100, 32'd7);
      bus.flush = 1'b1;
      #1;
      chk("flush_accept_stall", 32'(bus.md_stall), 32'd0);
      tick();
      bus.flush    = 1'b0;
      bus.ex_valid = 1'b0;
      #1;
      chk("flush_accept_idle", 32'(bus.md_stall), 32'd0);
      chk("flush_accept_done", 32'(bus.md_done), 32'd0);
      tick();

      // Back-to-back MUL then DIVU; DIVU is presented during DONE and must wait one cycle.
      run_op(3'b000, 32'd7, 32'hFFFFFFFD, res, lat, stalls);
      chk("b2b_mul_result", res, 32'hFFFFFFEB);
      chk("b2b_mul_latency", 32'(lat), 32'(MUL_LAT));
      drive_m(3'b101, 32'd100, 32'd7);
      tick();
      run_op(3'b101, 32'd100, 32'd7, res, lat, stalls);
      chk("b2b_divu_result", res, 32'd14);
      chk("b2b_divu_latency", 32'(lat), 32'(DIV_LAT));
      tick();

      // Flush ten cycles into a DIVU: no done, result retained, next op accepted at once.
      drive_m(3'b101, 32'd1000, 32'd3);
      tick();
      bus.ex_valid = 1'b0;
      repeat (9) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("midflush_idle", 32'(bus.md_stall), 32'd0);
      chk("midflush_done", 32'(bus.md_done), 32'd0);
      chk("midflush_result_held", bus.md_result, 32'd14);
      run_op(3'b000, 32'd7, 32'hFFFFFFFD, res, lat, stalls);
      chk("postflush_result", res, 32'hFFFFFFEB);
      chk("postflush_latency", 32'(lat), 32'(MUL_LAT));
      tick();

      // Asynchronous reset in the middle of a divide.
      drive_m(3'b100, 32'hFFFFFFEC, 32'd3);
      tick();
      bus.ex_valid = 1'b0;
      repeat (5) tick();
      chk("middiv_busy", 32'(bus.md_stall), 32'd1);
      reset = 1'b0;
      #1;
      chk("middiv_reset_stall", 32'(bus.md_stall), 32'd0);
      chk("middiv_reset_done", 32'(bus.md_done), 32'd0);
      chk("middiv_reset_result", bus.md_result, 32'd0);
      tick();
      reset    = 1'b1;
      spurious = 0;
      repeat (40) begin
         tick();
         if (bus.md_done) spurious++;
      end
      chk("middiv_no_spurious_done", 32'(spurious), 32'd0);

      // Randomised ops against the reference model.
      for (int i = 0; i < 40; i++) begin
         rf3 = 3'($urandom_range(0, 7));
         ra  = pick();
         rb  = pick();
         run_op(rf3, ra, rb, res, lat, stalls);
         chk($sformatf("rand%0d_f3_%0d_result", i, rf3), res, ref_res(rf3, ra, rb));
         chk($sformatf("rand%0d_f3_%0d_latency", i, rf3), 32'(lat), 32'(ref_lat(rf3, ra, rb)));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
